mini_alu_arbiter: RTL and testbench
===================================

Name: mini_alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one MiniAlu execution slot between NUM_REQ requesters.
- Captures the winning requester's opcode and operands, starts the ALU, waits for completion, then returns the tagged result.
- Sits between requester blocks (LED/display controllers, test sequencers) and the MiniAlu operand/result interface.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- ID_W, 2, width of requester index; must equal ceil(log2(NUM_REQ)).
- OP_W, 4, ALU opcode width.
- DATA_W, 8, operand width; result width is 2*DATA_W.
- TIMEOUT, 15, maximum cycles spent in WAIT (used only with TIMEOUT_EN).

Ports:
- Clock  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous reset, active-low.
- iReq  in  NUM_REQ  request per requester; level, held until that requester's oGnt bit pulses.
- iOp  in  NUM_REQ*OP_W  flattened opcodes; requester i at [i*OP_W +: OP_W].
- iA  in  NUM_REQ*DATA_W  flattened operand A, same packing.
- iB  in  NUM_REQ*DATA_W  flattened operand B, same packing.
- oGnt  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted, operands captured.
- oAluStart  out  1  1-cycle start pulse to the ALU.
- oAluOp  out  OP_W  registered opcode; stable from ISSUE until return to IDLE.
- oAluA  out  DATA_W  registered operand A; stable from ISSUE until return to IDLE.
- oAluB  out  DATA_W  registered operand B; stable from ISSUE until return to IDLE.
- iAluDone  in  1  ALU completion strobe.
- iAluResult  in  2*DATA_W  ALU result; valid while iAluDone=1.
- oValid  out  1  1-cycle result strobe.
- oResult  out  2*DATA_W  captured result; holds its value until the next RESP.
- oRespId  out  ID_W  index of the requester the result belongs to.
- oBusy  out  1  high in every state except IDLE.
- oError  out  1  timeout flag; qualified by oValid.

Behaviour:
- Reset (Reset=0 at a rising edge): state=IDLE, priority pointer=0.
  - All outputs reset to 0: oGnt, oAluStart, oAluOp/A/B, oValid, oResult, oRespId, oBusy, oError.
  - Reset wins over any in-flight operation: the pending result is discarded and no oValid is emitted.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If iReq≠0, the winner is the first set bit searching upward (with wrap) from the pointer.
  - Next edge: latch the winner's op/A/B and index; oGnt[winner]=1 for one cycle; pointer=(winner+1) mod NUM_REQ; state→ISSUE.
  - If iReq=0: stay in IDLE; pointer unchanged.
- ISSUE: oAluStart=1 for exactly this cycle; iAluDone is ignored; →WAIT.
- WAIT:
  - On iAluDone=1: capture iAluResult into oResult, set oRespId=latched index; →RESP.
  - Otherwise stay in WAIT.
- RESP: oValid=1 for one cycle (oError=0 unless timeout); →IDLE.
- Latency:
  - Request sampled in IDLE at edge T: oGnt high during T+1, oAluStart during T+2.
  - iAluDone seen at edge T+2+k (k≥1): oValid high during T+3+k.
  - Minimum turnaround is 4 cycles per transaction; back-to-back requests are re-arbitrated in IDLE.
- Requests arriving in non-IDLE states wait; they are never lost while iReq is held.
- Dropping iReq before grant withdraws the request with no side effect.
- Pointer wrap: after granting NUM_REQ-1, the pointer becomes 0.
- Fairness: with all requests continuously held, grants rotate 0,1,2,3,0,...
- oGnt and oValid are never asserted in the same cycle.

Optional Feature:
- Macro: MINI_ALU_ARB_TIMEOUT_EN.
- Defined:
  - A 4-bit counter clears on entry to WAIT and increments each WAIT cycle without iAluDone.
  - On reaching TIMEOUT: →RESP with oValid=1, oError=1, oResult=0.
  - iAluDone in the same cycle as expiry takes priority: normal result, oError=0.
- Not defined: WAIT is unbounded; oError is tied to 0; no counter logic.

Test Plan:
- Reset=0 for 2 cycles with iReq=4'b1111 → all outputs 0, state IDLE; the first grant after release goes to requester 0.
- Single request: iReq=4'b0100, op=3, A=8'h12, B=8'h34; ALU done 3 cycles after start with result 16'h0046 → oGnt=4'b0100, oAluA=12, oAluB=34, then oValid with oResult=16'h0046, oRespId=2.
- Fairness: iReq=4'b1111 held for 8 transactions, ALU done 1 cycle after start → grant order 0,1,2,3,0,1,2,3, each oRespId matching its grant.
- Pointer wrap and skip: after a grant to 3, iReq=4'b0110 → next grant to 1, then to 2.
- Reset mid-operation: assert Reset=0 in WAIT, then pulse iAluDone → no oValid, oBusy=0, pointer back to 0.
- With MINI_ALU_ARB_TIMEOUT_EN, TIMEOUT=15, iAluDone never asserted → oValid=1, oError=1, oResult=0 after 15 WAIT cycles, then IDLE.

Source files
------------

// File: rtl/mini_alu_arbiter_if.sv
// Requester and ALU bundle around mini_alu_arbiter; names are from the arbiter's side.
// slave = arbiter view, master = requester/ALU side (testbench or integration wrapper).
interface mini_alu_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned DATA_W  = 8
);
  localparam int unsigned RES_W = 2 * DATA_W;

  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*OP_W-1:0]   i_op;
  logic [NUM_REQ*DATA_W-1:0] i_a;
  logic [NUM_REQ*DATA_W-1:0] i_b;
  logic [NUM_REQ-1:0]        o_gnt;
  logic                      o_alu_start;
  logic [OP_W-1:0]           o_alu_op;
  logic [DATA_W-1:0]         o_alu_a;
  logic [DATA_W-1:0]         o_alu_b;
  logic                      i_alu_done;
  logic [RES_W-1:0]          i_alu_result;
  logic                      o_valid;
  logic [RES_W-1:0]          o_result;
  logic [ID_W-1:0]           o_resp_id;
  logic                      o_busy;
  logic                      o_error;

  modport slave (
    input  i_req, i_op, i_a, i_b, i_alu_done, i_alu_result,
    output o_gnt, o_alu_start, o_alu_op, o_alu_a, o_alu_b,
           o_valid, o_result, o_resp_id, o_busy, o_error
  );

  modport master (
    output i_req, i_op, i_a, i_b, i_alu_done, i_alu_result,
    input  o_gnt, o_alu_start, o_alu_op, o_alu_a, o_alu_b,
           o_valid, o_result, o_resp_id, o_busy, o_error
  );
endinterface

// File: rtl/mini_alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one MiniAlu slot between NUM_REQ requesters.
// Optional WAIT timeout enabled by defining MINI_ALU_ARB_TIMEOUT_EN.
module mini_alu_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input logic             i_clk,
  input logic             i_rst_n,
  mini_alu_arbiter_if.slave bus
);
  localparam int unsigned RES_W = 2 * DATA_W;
  localparam int unsigned CNT_W = 4;

  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("ID_W must equal clog2(NUM_REQ)");
  end
  if (TIMEOUT < 1 || TIMEOUT > (1 << CNT_W) - 1) begin : g_bad_timeout
    $error("TIMEOUT must fit the 4-bit WAIT counter");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [ID_W-1:0]     r_ptr, w_ptr, r_id, w_id, w_win, w_scan;
  logic                w_any, w_expire;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt;
  logic                r_start, w_start, r_valid, w_valid, r_busy, w_busy, r_error, w_error;
  logic [OP_W-1:0]     r_op, w_op;
  logic [DATA_W-1:0]   r_a, w_a, r_b, w_b;
  logic [RES_W-1:0]    r_result, w_result;
  logic [ID_W-1:0]     r_resp_id, w_resp_id;

  // First set request at or above the pointer, wrapping; lowest offset wins.
  always_comb begin
    w_any  = |bus.i_req;
    w_win  = '0;
    w_scan = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      w_scan = ID_W'((int'(r_ptr) + k) % int'(NUM_REQ));
      if (bus.i_req[w_scan]) w_win = w_scan;
    end
  end

`ifdef MINI_ALU_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  assign w_expire = (r_state == S_WAIT) && !bus.i_alu_done && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || r_state != S_WAIT) r_cnt <= '0;
    else if (!bus.i_alu_done)          r_cnt <= r_cnt + CNT_W'(1);
  end
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.i_alu_done || w_expire) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; ALU done in ISSUE is deliberately ignored.
  always_comb begin
    w_gnt     = '0;
    w_start   = 1'b0;
    w_valid   = 1'b0;
    w_error   = 1'b0;
    w_op      = r_op;
    w_a       = r_a;
    w_b       = r_b;
    w_id      = r_id;
    w_ptr     = r_ptr;
    w_result  = r_result;
    w_resp_id = r_resp_id;
    w_busy    = (w_state_nxt != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_gnt = NUM_REQ'(1) << w_win;
          w_id  = w_win;
          w_ptr = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (ID_W'(i) == w_win) begin
              w_op = bus.i_op[i*OP_W +: OP_W];
              w_a  = bus.i_a[i*DATA_W +: DATA_W];
              w_b  = bus.i_b[i*DATA_W +: DATA_W];
            end
          end
        end
      end
      S_ISSUE: w_start = 1'b1;
      S_WAIT: begin
        if (bus.i_alu_done) begin
          w_valid   = 1'b1;
          w_result  = bus.i_alu_result;
          w_resp_id = r_id;
        end else if (w_expire) begin
          w_valid   = 1'b1;
          w_error   = 1'b1;
          w_result  = '0;
          w_resp_id = r_id;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_gnt     <= '0;
      r_start   <= 1'b0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_busy    <= 1'b0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= '0;
      r_ptr     <= '0;
      r_result  <= '0;
      r_resp_id <= '0;
    end else begin
      r_gnt     <= w_gnt;
      r_start   <= w_start;
      r_valid   <= w_valid;
      r_error   <= w_error;
      r_busy    <= w_busy;
      r_op      <= w_op;
      r_a       <= w_a;
      r_b       <= w_b;
      r_id      <= w_id;
      r_ptr     <= w_ptr;
      r_result  <= w_result;
      r_resp_id <= w_resp_id;
    end
  end

  assign bus.o_gnt       = r_gnt;
  assign bus.o_alu_start = r_start;
  assign bus.o_alu_op    = r_op;
  assign bus.o_alu_a     = r_a;
  assign bus.o_alu_b     = r_b;
  assign bus.o_valid     = r_valid;
  assign bus.o_result    = r_result;
  assign bus.o_resp_id   = r_resp_id;
  assign bus.o_busy      = r_busy;
  assign bus.o_error     = r_error;
endmodule

// File: tb/tb_mini_alu_arbiter.sv
// Bench for mini_alu_arbiter: directed scenarios plus randomized transactions against a
// round-robin reference model. Define MINI_ALU_ARB_TIMEOUT_EN to also cover the timeout.
module tb_mini_alu_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RES_W   = 16;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mini_alu_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .OP_W(OP_W), .DATA_W(DATA_W)) bus ();

  mini_alu_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .OP_W(OP_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int model_ptr = 0;
  logic [OP_W-1:0]   m_op [NUM_REQ];
  logic [DATA_W-1:0] m_a  [NUM_REQ];
  logic [DATA_W-1:0] m_b  [NUM_REQ];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Round-robin rule: first requester at or after the pointer, wrapping around.
  function automatic int ref_winner(input logic [NUM_REQ-1:0] req, input int ptr);
    for (int k = 0; k < int'(NUM_REQ); k++)
      if (req[(ptr + k) % int'(NUM_REQ)]) return (ptr + k) % int'(NUM_REQ);
    return -1;
  endfunction

  task automatic drive_operands();
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      m_op[i] = OP_W'($urandom);
      m_a[i]  = DATA_W'($urandom);
      m_b[i]  = DATA_W'($urandom);
      bus.i_op[i*OP_W +: OP_W]   = m_op[i];
      bus.i_a[i*DATA_W +: DATA_W] = m_a[i];
      bus.i_b[i*DATA_W +: DATA_W] = m_b[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  // One full transaction: grant, start, ALU done dly cycles after start, response.
  task automatic do_txn(input logic [NUM_REQ-1:0] req, input int dly, input logic [RES_W-1:0] res,
                        input bit fix, input logic [OP_W-1:0] fop, input logic [DATA_W-1:0] fa,
                        input logic [DATA_W-1:0] fb, input string tag);
    int win;
    int lat;
    logic [OP_W-1:0]   e_op;
    logic [DATA_W-1:0] e_a, e_b;
    win = ref_winner(req, model_ptr);
    drive_operands();
    if (fix) begin
      m_op[win] = fop; m_a[win] = fa; m_b[win] = fb;
      bus.i_op[win*OP_W +: OP_W]    = fop;
      bus.i_a[win*DATA_W +: DATA_W] = fa;
      bus.i_b[win*DATA_W +: DATA_W] = fb;
    end
    bus.i_req = req;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (bus.o_gnt == '0 && lat < 20);
    check_eq({tag, "_gnt"}, 32'(bus.o_gnt), 32'(1) << win);
    if (bus.o_gnt == '0) return;
    check_eq({tag, "_gnt_lat"}, 32'(lat), 32'd1);
    check_eq({tag, "_gnt_novalid"}, 32'(bus.o_valid), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
    e_op = m_op[win]; e_a = m_a[win]; e_b = m_b[win];
    check_eq({tag, "_op"}, 32'(bus.o_alu_op), 32'(e_op));
    check_eq({tag, "_a"}, 32'(bus.o_alu_a), 32'(e_a));
    check_eq({tag, "_b"}, 32'(bus.o_alu_b), 32'(e_b));
    model_ptr = (win + 1) % int'(NUM_REQ);
    drive_operands();
    tick();
    check_eq({tag, "_start"}, 32'(bus.o_alu_start), 32'd1);
    check_eq({tag, "_start_nognt"}, 32'(bus.o_gnt), 32'd0);
    tick();
    check_eq({tag, "_start_pulse"}, 32'(bus.o_alu_start), 32'd0);
    repeat (dly - 1) tick();
    bus.i_alu_done   = 1'b1;
    bus.i_alu_result = res;
    tick();
    bus.i_alu_done   = 1'b0;
    bus.i_alu_result = RES_W'($urandom);
    check_eq({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
    check_eq({tag, "_result"}, 32'(bus.o_result), 32'(res));
    check_eq({tag, "_resp_id"}, 32'(bus.o_resp_id), 32'(win));
    check_eq({tag, "_error"}, 32'(bus.o_error), 32'd0);
    check_eq({tag, "_valid_nognt"}, 32'(bus.o_gnt), 32'd0);
    check_eq({tag, "_a_hold"}, 32'(bus.o_alu_a), 32'(e_a));
    tick();
    check_eq({tag, "_valid_pulse"}, 32'(bus.o_valid), 32'd0);
    check_eq({tag, "_idle"}, 32'(bus.o_busy), 32'd0);
    check_eq({tag, "_result_hold"}, 32'(bus.o_result), 32'(res));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus.i_req        = 4'b1111;
    bus.i_alu_done   = 1'b0;
    bus.i_alu_result = '0;
    drive_operands();
    repeat (2) tick();
    check_eq("rst_gnt", 32'(bus.o_gnt), 32'd0);
    check_eq("rst_start", 32'(bus.o_alu_start), 32'd0);
    check_eq("rst_op", 32'(bus.o_alu_op), 32'd0);
    check_eq("rst_a", 32'(bus.o_alu_a), 32'd0);
    check_eq("rst_b", 32'(bus.o_alu_b), 32'd0);
    check_eq("rst_valid", 32'(bus.o_valid), 32'd0);
    check_eq("rst_result", 32'(bus.o_result), 32'd0);
    check_eq("rst_resp_id", 32'(bus.o_resp_id), 32'd0);
    check_eq("rst_busy", 32'(bus.o_busy), 32'd0);
    check_eq("rst_error", 32'(bus.o_error), 32'd0);
    rst_n = 1'b1;
    model_ptr = 0;
    do_txn(4'b1111, 1, 16'h1234, 1'b0, '0, '0, '0, "first");

    do_txn(4'b0100, 3, 16'h0046, 1'b1, 4'd3, 8'h12, 8'h34, "single");

    do_reset();
    for (int t = 0; t < 8; t++)
      do_txn(4'b1111, 1, RES_W'($urandom), 1'b0, '0, '0, '0, $sformatf("fair%0d", t));

    do_txn(4'b1000, 2, RES_W'($urandom), 1'b0, '0, '0, '0, "wrap3");
    do_txn(4'b0110, 1, RES_W'($urandom), 1'b0, '0, '0, '0, "skip1");
    do_txn(4'b0110, 1, RES_W'($urandom), 1'b0, '0, '0, '0, "skip2");

    // Reset while the ALU is busy: the late done must not produce a response.
    bus.i_req = 4'b0010;
    tick();
    check_eq("mid_gnt", 32'(bus.o_gnt), 32'b0010);
    bus.i_req = '0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("mid_busy", 32'(bus.o_busy), 32'd0);
    check_eq("mid_valid", 32'(bus.o_valid), 32'd0);
    bus.i_alu_done = 1'b1;
    tick();
    bus.i_alu_done = 1'b0;
    check_eq("mid_valid2", 32'(bus.o_valid), 32'd0);
    rst_n = 1'b1;
    model_ptr = 0;
    tick();
    check_eq("mid_valid3", 32'(bus.o_valid), 32'd0);
    do_txn(4'b1111, 1, RES_W'($urandom), 1'b0, '0, '0, '0, "post_rst");

    for (int t = 0; t < 24; t++) begin
      logic [NUM_REQ-1:0] req;
      req = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      do_txn(req, int'($urandom_range(1, 4)), RES_W'($urandom), 1'b0, '0, '0, '0,
             $sformatf("rnd%0d", t));
    end

`ifdef MINI_ALU_ARB_TIMEOUT_EN
    begin
      int n;
      int win;
      win = ref_winner(4'b0001, model_ptr);
      bus.i_req = 4'b0001;
      tick();
      check_eq("to_gnt", 32'(bus.o_gnt), 32'(1) << win);
      bus.i_req = '0;
      model_ptr = (win + 1) % int'(NUM_REQ);
      tick();
      check_eq("to_start", 32'(bus.o_alu_start), 32'd1);
      n = 0;
      do begin
        tick();
        n++;
      end while (!bus.o_valid && n < 40);
      check_eq("to_valid", 32'(bus.o_valid), 32'd1);
      check_eq("to_cycles", 32'(n), 32'(TIMEOUT));
      check_eq("to_error", 32'(bus.o_error), 32'd1);
      check_eq("to_result", 32'(bus.o_result), 32'd0);
      check_eq("to_resp_id", 32'(bus.o_resp_id), 32'(win));
      tick();
      check_eq("to_idle", 32'(bus.o_busy), 32'd0);
      check_eq("to_valid_pulse", 32'(bus.o_valid), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
